// File: rtl/interp_filter_pkg.sv
// Shared constants and helpers for the multi-channel Farrow interpolator.
// Width helpers are functions so every module derives them from its own parameters.
package interp_filter_pkg;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 14;
    localparam int DEF_MU_W   = 14;

    localparam logic MODE_PARABOLIC = 1'b0;
    localparam logic MODE_LINEAR    = 1'b1;

    // Stage-1 coefficients are kept doubled, so they need three guard bits.
    function automatic int f_width(input int data_w);
        return data_w + 3;
    endfunction

    function automatic int p_width(input int data_w, input int mu_w);
        return f_width(data_w) + mu_w + 1;
    endfunction

    // Drop 'shift' fractional bits with round-half-up, then clamp to out_w signed bits.
    function automatic logic signed [31:0] round_sat(input logic signed [63:0] acc,
                                                     input int shift, input int out_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r[31:0];
    endfunction

endpackage

// File: rtl/interp_filter_if.sv
// Sample-in / interpolant-out handshake bundle of the interpolator.
interface interp_filter_if import interp_filter_pkg::*; #(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MU_W   = DEF_MU_W
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic [MU_W-1:0]            in_mu;
    logic                       in_strobe;
    logic                       in_mode;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_CH*DATA_W-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_mu, in_strobe, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mu, in_strobe, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/interp_filter_dp.sv
// One channel: 4-tap delay line followed by the 3-stage Farrow datapath.
// All coefficient arithmetic is exact; the only rounding happens at the output.
module interp_filter_dp import interp_filter_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int MU_W   = DEF_MU_W
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     shift_en,
    input  logic                     adv_en,
    input  logic                     load_en,
    input  logic                     mode,
    input  logic [MU_W-1:0]          mu_s1,
    input  logic [MU_W-1:0]          mu_s2,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);
    localparam int F_W      = f_width(DATA_W);
    localparam int P_W      = p_width(DATA_W, MU_W);
    localparam int Y_W      = P_W + MU_W + 1;
    localparam int ACC_FRAC = FRAC_W + 2 * MU_W + 1;

    logic signed [DATA_W-1:0] b1_reg, b2_reg, b3_reg, b4_reg;
    logic signed [F_W-1:0]    e1, e2, e3, e4;
    logic signed [F_W-1:0]    f1_next, f2_next, f3_next;
    logic signed [F_W-1:0]    f1_reg, f2_reg, f3_reg, f3_s2_reg;
    logic signed [MU_W:0]     mu1_ext, mu2_ext;
    logic signed [P_W-1:0]    p_next, p_reg;
    logic signed [Y_W-1:0]    y_acc;
    logic signed [DATA_W-1:0] y_reg;

    assign e1 = F_W'(b1_reg);
    assign e2 = F_W'(b2_reg);
    assign e3 = F_W'(b3_reg);
    assign e4 = F_W'(b4_reg);

    // Doubled coefficients: the parabolic 0.5 factors stay integral.
    always_comb begin
        f1_next = '0;
        f2_next = '0;
        if (mode == MODE_PARABOLIC) begin
            f1_next = e1 - e2 - e3 + e4;
            f2_next = e2 + e2 + e2 - e1 - e3 - e4;
        end else begin
            f2_next = (e2 - e3) <<< 1;
        end
    end
    assign f3_next = e3 <<< 1;

    assign mu1_ext = {1'b0, mu_s1};
    assign mu2_ext = {1'b0, mu_s2};
    assign p_next  = P_W'(f1_reg) * P_W'(mu1_ext) + (P_W'(f2_reg) <<< MU_W);
    assign y_acc   = Y_W'(p_reg) * Y_W'(mu2_ext) + (Y_W'(f3_s2_reg) <<< (2 * MU_W));

    always_ff @(posedge clk) begin
        if (srst) begin
            b1_reg    <= '0;
            b2_reg    <= '0;
            b3_reg    <= '0;
            b4_reg    <= '0;
            f1_reg    <= '0;
            f2_reg    <= '0;
            f3_reg    <= '0;
            f3_s2_reg <= '0;
            p_reg     <= '0;
            y_reg     <= '0;
        end else begin
            if (shift_en) begin
                b4_reg <= b3_reg;
                b3_reg <= b2_reg;
                b2_reg <= b1_reg;
                b1_reg <= din;
            end
            if (adv_en) begin
                f1_reg    <= f1_next;
                f2_reg    <= f2_next;
                f3_reg    <= f3_next;
                p_reg     <= p_next;
                f3_s2_reg <= f3_reg;
            end
            if (load_en) begin
                y_reg <= DATA_W'(round_sat(64'(y_acc), ACC_FRAC - FRAC_W, DATA_W));
            end
        end
    end

    assign dout = y_reg;
endmodule

// File: rtl/interp_filter_mch.sv
// Lock-step multi-channel Farrow interpolator: fill counter, valid/mu/mode pipeline
// and a single global stall shared by every channel datapath.
module interp_filter_mch import interp_filter_pkg::*; #(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int MU_W   = DEF_MU_W
) (
    input logic            clk,
    input logic            rst,
    interp_filter_if.slave bus
);
    logic                     stall;
    logic                     accept;
    logic [2:0]               fill_reg, fill_next;
    logic                     v0_reg, v1_reg, v2_reg, out_valid_reg;
    logic                     mode_s0_reg;
    logic [MU_W-1:0]          mu_s0_reg, mu_s1_reg, mu_s2_reg;
    logic [NUM_CH*DATA_W-1:0] out_data_w;

    assign stall     = out_valid_reg && !bus.out_ready;
    assign accept    = bus.in_valid && !stall;
    assign fill_next = (fill_reg == 3'd4) ? 3'd4 : fill_reg + 3'd1;

    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_w;

    // Strobes arriving before four samples are in the delay line are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_reg      <= '0;
            v0_reg        <= 1'b0;
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            mode_s0_reg   <= MODE_PARABOLIC;
            mu_s0_reg     <= '0;
            mu_s1_reg     <= '0;
            mu_s2_reg     <= '0;
        end else if (!stall) begin
            if (accept) begin
                fill_reg    <= fill_next;
                mode_s0_reg <= bus.in_mode;
                mu_s0_reg   <= bus.in_mu;
            end
            v0_reg        <= accept && bus.in_strobe && (fill_next == 3'd4);
            v1_reg        <= v0_reg;
            mu_s1_reg     <= mu_s0_reg;
            v2_reg        <= v1_reg;
            mu_s2_reg     <= mu_s1_reg;
            out_valid_reg <= v2_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            interp_filter_dp #(
                .DATA_W (DATA_W),
                .FRAC_W (FRAC_W),
                .MU_W   (MU_W)
            ) u_dp (
                .clk      (clk),
                .srst     (rst),
                .shift_en (accept),
                .adv_en   (!stall),
                .load_en  (!stall && v2_reg),
                .mode     (mode_s0_reg),
                .mu_s1    (mu_s1_reg),
                .mu_s2    (mu_s2_reg),
                .din      (bus.in_data[gi*DATA_W +: DATA_W]),
                .dout     (out_data_w[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate
endmodule

// File: doc/interp_filter_mch.md
Name: interp_filter_mch

Overview:
Parametrised successor to the symbol-sync Farrow interpolator.
- Filters NUM_CH channels in lock-step. I/Q is the case NUM_CH=2.
- Selectable per sample: piecewise-parabolic (alpha=0.5) or linear interpolation.
- Valid/ready handshakes on both sides, 3-stage pipeline, and per-sample strobe decimation.
- Sits between the matched filter and the Gardner TED; mu and strobe come from the NCO/loop controller.

Parameters:
NUM_CH, 2, number of lock-step channels
DATA_W, 16, signed sample width per channel
FRAC_W, 14, fractional bits of samples (1.0 = 2^FRAC_W)
MU_W, 14, unsigned fractional-interval width; mu value = mu/2^MU_W, range [0,1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample vector valid
in_ready  out  1  block can accept
in_data  in  NUM_CH*DATA_W  packed signed samples, channel 0 in LSBs
in_mu  in  MU_W  fractional interval for this sample
in_strobe  in  1  produce an interpolant for this sample
in_mode  in  1  0 = parabolic, 1 = linear
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts
out_data  out  NUM_CH*DATA_W  packed interpolants

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: delay lines 0, fill count 0, all pipeline valids 0, out_valid 0, out_data 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards in-flight results; nothing is emitted for them.
- Accept: a sample is accepted when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall. While stalled, all stages, the delay lines and out_data hold.
- Delay line: per channel, B1 (newest) .. B4 (oldest). It shifts only on accept.
- Fill counter: saturates at 4. A stage-1 entry is valid only if the sample is accepted AND in_strobe=1 AND the counter, after including this sample, equals 4. Strobes during fill are dropped silently.
- mu and mode are captured with the sample and travel with it. in_mode may change every sample without corrupting the others.
- Stage 1, per channel, exact arithmetic, stored as 2x values to keep the 0.5 factors:
  - f1 = 0.5(B1 - B2 - B3 + B4)
  - f2 = -0.5·B1 + 1.5·B2 - 0.5·B3 - 0.5·B4
  - f3 = B3
  - Linear mode forces f1 = 0, f2 = B2 - B3, f3 = B3.
- Stage 2: p = f1·mu + f2. Full precision, no truncation.
- Stage 3: y = p·mu + f3. Round half-up to FRAC_W fractional bits, then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Latency: exactly 3 clk edges from an accepting edge to out_valid=1, absent stalls. Throughput is 1 sample/cycle. Non-strobe samples create bubbles.
- out_valid deasserts on the cycle after a handshake unless the next stage holds a valid result.
- Channels are independent; saturation in one does not affect the others.

Decomposition:
- Package interp_filter_pkg:
  - MODE_PARABOLIC / MODE_LINEAR constants
  - internal width constants: F_W = DATA_W+3; P_W = F_W+MU_W+1
  - round-and-saturate function
- Sub-module interp_filter_dp: one channel's delay line and 3-stage datapath, with shift/advance enables as inputs. Instantiated NUM_CH times via generate.
- Top level holds the fill counter, valid pipeline, stall logic and the mu/mode pipeline.

Test Plan:
1. Constant fill: all channels 8192, strobe every sample, mu swept 0..16383, both modes -> first out_valid 3 cycles after the 4th accept; every output 8192.
2. Ramp: accept 1024, 2048, 3072, 4096 (B1=4096), mu=8192, strobe on the 4th sample -> parabolic 2560; repeat in linear mode -> 2560; mu=0 -> 2048 in both modes.
3. Saturation: ch0 history B4..B1 = 32767, -32768, -32768, 32767, mu=8192 -> ch0 out -32768. ch1 ramp as in test 2 -> 2560 in the same beat.
4. Back-pressure: continuous strobed stream, out_ready low for 5 cycles mid-stream -> in_ready low in those cycles; out_data is held; no sample is lost or duplicated versus the reference model.
5. Decimation/fill: strobe only every 2nd accepted sample, strobes also issued during fill -> no outputs before fill completes; then one output per strobe with the correct mu alignment.
6. Reset: assert rst for 1 cycle with 3 results in flight -> next cycle out_valid=0, out_data=0; the next strobe gives output only after 4 fresh accepts.
